// File: rtl/rans_dec.sv
// rans_dec: single-lane rANS decoder.
// Loads the encoder's frequency/cumulative-frequency table and expands it into a
// slot-to-symbol lookup. It then pulls encoded bytes through a valid/ready
// handshake and emits decoded symbols through a second valid/ready handshake.
// Optional feature macro: RANS_DEC_FINAL_CHECK_EN builds the final-state
// comparator behind err_o. When the macro is undefined, err_o is tied low.
module rans_dec #(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8,
    parameter int STATE_WIDTH  = 32,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    freq_wr_i,
    input  logic [SYMBOL_WIDTH-1:0] symb_i,
    input  logic [RESOLUTION:0]     freq_i,
    input  logic [RESOLUTION-1:0]   cum_freq_i,
    output logic                    ready_o,
    input  logic                    start_i,
    input  logic [COUNT_WIDTH-1:0]  count_i,
    input  logic                    enc_valid_i,
    input  logic [7:0]              enc_i,
    output logic                    enc_ready_o,
    output logic                    valid_o,
    output logic [SYMBOL_WIDTH-1:0] symb_o,
    input  logic                    symb_ready_i,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int M      = 1 << RESOLUTION;
    localparam int NSYM   = 1 << SYMBOL_WIDTH;
    localparam int NBYTES = STATE_WIDTH / 8;
    localparam int BCW    = $clog2(NBYTES) + 1;
    localparam int FW     = RESOLUTION + 1;
    // Lower bound of the normalised state interval; also the encoder's initial state.
    localparam logic [STATE_WIDTH-1:0] L_BOUND = {8'd1, {(STATE_WIDTH-8){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, FILL, INIT, LOOK1, LOOK2, UPDATE, EMIT, RENORM
    } state_t;

    state_t                  state_q, state_d;
    logic [STATE_WIDTH-1:0]  x_q, x_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic [BCW-1:0]          byte_cnt_q, byte_cnt_d;
    logic [SYMBOL_WIDTH-1:0] fill_sym_q, fill_sym_d;
    logic [RESOLUTION-1:0]   fill_addr_q, fill_addr_d;
    logic [FW-1:0]           fill_cnt_q, fill_cnt_d;
    logic [SYMBOL_WIDTH-1:0] symb_q, symb_d;
    logic                    done_q, done_d;

    // Table storage and registered (synchronous) read data.
    logic [FW-1:0]           freq_ram [NSYM];
    logic [RESOLUTION-1:0]   cum_ram  [NSYM];
    logic [SYMBOL_WIDTH-1:0] slot_tbl [M];
    logic [SYMBOL_WIDTH-1:0] rd_sym_q;
    logic [FW-1:0]           rd_freq_q;
    logic [RESOLUTION-1:0]   rd_cum_q;

    logic                    tbl_wr, fill_wr, sym_done;
    logic [STATE_WIDTH-1:0]  byte_x, prod, x_upd;

    assign tbl_wr  = (state_q == IDLE) && freq_wr_i;
    assign fill_wr = (state_q == FILL) && (fill_cnt_q != '0);
    assign byte_x  = {x_q[STATE_WIDTH-9:0], enc_i};
    assign prod    = STATE_WIDTH'(rd_freq_q) * (x_q >> RESOLUTION);
    assign x_upd   = prod + STATE_WIDTH'(x_q[RESOLUTION-1:0]) - STATE_WIDTH'(rd_cum_q);

    assign ready_o     = (state_q == IDLE);
    assign enc_ready_o = (state_q == INIT) || (state_q == RENORM);
    assign valid_o     = (state_q == EMIT);
    assign symb_o      = symb_q;
    assign done_o      = done_q;

    // Table writes, slot expansion and the two pipelined lookups.
    // NOTE: RAM arrays sit in a reset-free process so they map to block memory;
    // their contents survive reset and are reloaded by the user when needed.
    always_ff @(posedge clk_i) begin
        if (tbl_wr) begin
            freq_ram[symb_i] <= freq_i;
            cum_ram[symb_i]  <= cum_freq_i;
        end
        if (fill_wr) begin
            slot_tbl[fill_addr_q] <= fill_sym_q;
        end
        if (state_q == LOOK1) begin
            rd_sym_q <= slot_tbl[x_q[RESOLUTION-1:0]];
        end
        if (state_q == LOOK2) begin
            rd_freq_q <= freq_ram[rd_sym_q];
            rd_cum_q  <= cum_ram[rd_sym_q];
        end
    end

    // Next-state and datapath decisions for the decoder FSM.
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        count_d     = count_q;
        byte_cnt_d  = byte_cnt_q;
        fill_sym_d  = fill_sym_q;
        fill_addr_d = fill_addr_q;
        fill_cnt_d  = fill_cnt_q;
        symb_d      = symb_q;
        done_d      = 1'b0;
        sym_done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (freq_wr_i) begin
                    fill_sym_d  = symb_i;
                    fill_addr_d = cum_freq_i;
                    fill_cnt_d  = freq_i;
                    state_d     = FILL;
                end else if (start_i) begin
                    count_d    = count_i;
                    byte_cnt_d = '0;
                    if (count_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = INIT;
                    end
                end
            end
            FILL: begin
                // Slot address wraps naturally at RESOLUTION bits.
                fill_addr_d = fill_addr_q + RESOLUTION'(1);
                if (fill_cnt_q != '0) begin
                    fill_cnt_d = fill_cnt_q - FW'(1);
                end
                if (fill_cnt_q <= FW'(1)) begin
                    state_d = IDLE;
                end
            end
            INIT: begin
                if (enc_valid_i) begin
                    x_d        = byte_x;
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    if (byte_cnt_q == BCW'(NBYTES - 1)) begin
                        state_d = LOOK1;
                    end
                end
            end
            LOOK1:  state_d = LOOK2;
            LOOK2:  state_d = UPDATE;
            UPDATE: begin
                x_d     = x_upd;
                symb_d  = rd_sym_q;
                state_d = EMIT;
            end
            EMIT: begin
                if (symb_ready_i) begin
                    // Skip RENORM entirely when the state is already normalised.
                    if (x_q >= L_BOUND) begin
                        sym_done = 1'b1;
                    end else begin
                        state_d = RENORM;
                    end
                end
            end
            RENORM: begin
                if (enc_valid_i) begin
                    x_d = byte_x;
                    if (byte_x >= L_BOUND) begin
                        sym_done = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (sym_done) begin
            count_d = count_q - COUNT_WIDTH'(1);
            if (count_q == COUNT_WIDTH'(1)) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = LOOK1;
            end
        end
    end

    // Control and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            x_q         <= '0;
            count_q     <= '0;
            byte_cnt_q  <= '0;
            fill_sym_q  <= '0;
            fill_addr_q <= '0;
            fill_cnt_q  <= '0;
            symb_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            count_q     <= count_d;
            byte_cnt_q  <= byte_cnt_d;
            fill_sym_q  <= fill_sym_d;
            fill_addr_q <= fill_addr_d;
            fill_cnt_q  <= fill_cnt_d;
            symb_q      <= symb_d;
            done_q      <= done_d;
        end
    end

`ifdef RANS_DEC_FINAL_CHECK_EN
    logic err_q, err_d;
    logic start_acc, finish_last;

    assign start_acc   = (state_q == IDLE) && start_i && !freq_wr_i;
    assign finish_last = done_d && (state_q != IDLE);

    // Sticky flag: the final state must equal the encoder's initial state.
    always_comb begin
        err_d = err_q;
        if (start_acc) begin
            err_d = 1'b0;
        end
        if (finish_last) begin
            err_d = (x_d != L_BOUND);
        end
    end

    // Error flag register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
